mcs_wb_bridge: RTL and testbench
================================

Name: mcs_wb_bridge

Overview:
- Bus initiator that turns MicroBlaze MCS I/O-bus strobes into single Wishbone classic cycles.
- Drives the master side of the Wishbone link into the MMIO slot decoder: one transaction in flight, registered outputs.
- Adds an address-window check, an ACK timeout with a fixed error response, and a saturating error counter for debug.

Parameters:
- ADDR_BASE, 32'hC000_0000, byte base address of the MMIO window.
- ADDR_MASK, 32'hFFFF_E000, mask applied to io_address before comparing with ADDR_BASE. 8 KB window = 2048 words.
- TIMEOUT_CYCLES, 255, maximum cycles waiting for ACK; valid range 1..65535.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- io_addr_strobe  in  1  MCS address strobe, single-cycle pulse.
- io_read_strobe  in  1  MCS read qualifier.
- io_write_strobe  in  1  MCS write qualifier.
- io_address  in  32  MCS byte address.
- io_byte_enable  in  4  MCS byte enables.
- io_write_data  in  32  MCS write data.
- io_read_data  out  32  read data to MCS, valid only while io_ready=1.
- io_ready  out  1  one-cycle completion pulse to MCS.
- wb  wishbone_if.master  -  CYC, STB, WE, ADDR[10:0], DAT_I[31:0] (bridge to slave), DAT_O[31:0] (slave to bridge), ACK.
- bus_timeout  out  1  one-cycle pulse when a cycle times out.
- err_count  out  8  saturating count of timeouts plus partial-byte-enable writes.

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, FSM in IDLE, timeout counter 0, err_count 0. Asserting reset mid-transaction drops CYC/STB immediately; the pending MCS access is abandoned and gets no io_ready.
- Request: accepted only in IDLE, on io_addr_strobe=1 with io_read_strobe or io_write_strobe=1.
- Both qualifiers set: treated as a write.
- Strobe while not IDLE: ignored; no queueing.
- On acceptance, latch:
  - WE = write;
  - ADDR = io_address[12:2];
  - DAT_I = io_write_data;
  - in_window = ((io_address & ADDR_MASK) == ADDR_BASE).
- FSM states: IDLE, BUS, DONE.
- IDLE -> BUS when the request is in window. CYC=STB=1 from the next cycle.
- IDLE -> DONE when the request is out of window. No bus cycle; read data 0.
- BUS:
  - CYC, STB, WE, ADDR and DAT_I are held stable.
  - Timeout counter increments every cycle.
  - If wb.ACK=1: register wb.DAT_O into io_read_data, drop CYC/STB the next cycle, go to DONE.
  - Else, when counter == TIMEOUT_CYCLES-1: drop CYC/STB, io_read_data=TIMEOUT_DATA, bus_timeout pulse, go to DONE.
  - ACK and timeout in the same cycle: ACK wins; no timeout is reported.
- DONE: io_ready=1 for exactly one cycle with io_read_data valid; return to IDLE. io_read_data returns to 0 on the following cycle.
- Latency:
  - Zero-wait slave (ACK in the first BUS cycle): io_ready 3 cycles after io_addr_strobe.
  - Each slave wait state adds 1 cycle.
  - Out-of-window access: 2 cycles.
- Write data for writes: io_read_data=0.
- Byte enables:
  - Only full-word accesses are supported. Wishbone carries no SEL.
  - A write with io_byte_enable != 4'hF is still issued as a full-word write and increments err_count.
  - Reads ignore byte enables.
- err_count saturates at 8'hFF, never wraps. Timeout and partial-enable events from the same access count as 2.
- Timeout counter width is 16 bits. It clears on entry to BUS.

Decomposition:
- In ft_mcs_pkg:
  - state enum bridge_state_t {IDLE, BUS, DONE};
  - localparam WB_ADDR_LSB=2, WB_ADDR_MSB=12;
  - default TIMEOUT_DATA constant.
- No sub-module. Timeout counter and saturating err counter stay inline.

Test Plan:
- Write 32'h1234_5678 to 32'hC000_0010, slave ACKs in first BUS cycle -> ADDR=11'h004, WE=1, DAT_I=32'h1234_5678, io_ready 3 cycles after strobe, err_count=0.
- Read 32'hC000_1FFC, slave returns 32'hA5A5_0001 after 4 wait states -> ADDR=11'h7FF, io_ready at cycle 7 with io_read_data=32'hA5A5_0001.
- Read 32'h8000_0000 (out of window) -> CYC never asserted, io_ready at cycle 2, io_read_data=0.
- Read in window, slave never ACKs, TIMEOUT_CYCLES=8 -> CYC held 8 cycles, bus_timeout pulse, io_read_data=32'hDEAD_BEEF, err_count=1. Repeat 300 times -> err_count=8'hFF.
- Write with io_byte_enable=4'h3 plus a second strobe issued during BUS -> single full-word write, second strobe ignored, err_count increments by 1.
- reset_n pulled low during BUS -> CYC/STB=0 asynchronously, no io_ready. A new read after reset release completes normally.

Source files
------------

// File: rtl/ft_mcs_pkg.sv
// Shared types and constants for the MCS I/O-bus to Wishbone bridge.
package ft_mcs_pkg;

  typedef enum logic [1:0] {IDLE, BUS, DONE} bridge_state_t;

  // Word-address slice of the MCS byte address carried on the Wishbone link.
  localparam int unsigned WB_ADDR_LSB = 2;
  localparam int unsigned WB_ADDR_MSB = 12;
  localparam int unsigned WB_ADDR_W   = WB_ADDR_MSB - WB_ADDR_LSB + 1;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone classic link between the bridge (master) and the MMIO slot decoder (slave).
interface wishbone_if;

  logic                             cyc;
  logic                             stb;
  logic                             we;
  logic [ft_mcs_pkg::WB_ADDR_W-1:0] addr;
  logic [31:0]                      dat_i;  // bridge to slave
  logic [31:0]                      dat_o;  // slave to bridge
  logic                             ack;

  modport master (output cyc, stb, we, addr, dat_i, input dat_o, ack);
  modport slave  (input cyc, stb, we, addr, dat_i, output dat_o, ack);

endinterface

// File: rtl/mcs_wb_bridge.sv
// Turns single MCS I/O-bus accesses into Wishbone classic cycles, with an address-window
// check, an ACK timeout returning a fixed word, and a saturating debug error counter.
module mcs_wb_bridge
  import ft_mcs_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'hC000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_E000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_address,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  wishbone_if.master  wb,
  output logic        bus_timeout,
  output logic [7:0]  err_count
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  bridge_state_t        state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [WB_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [15:0]          tcnt_q, tcnt_d;
  logic [31:0]          resp_q, resp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 timeout_q, timeout_d;
  logic [7:0]           err_q, err_d;

  logic       accept;
  logic       in_window;
  logic       partial;
  logic       expire;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign accept    = (state_q == IDLE) && io_addr_strobe && (io_read_strobe || io_write_strobe);
  assign in_window = (io_address & ADDR_MASK) == ADDR_BASE;
  // Only issued writes can lose bytes, so out-of-window writes are not counted.
  assign partial   = accept && io_write_strobe && in_window && (io_byte_enable != 4'hF);
  assign expire    = (state_q == BUS) && !wb.ack && (tcnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tcnt_q    <= '0;
      resp_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tcnt_q    <= tcnt_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_window ? BUS : DONE;
      BUS:     if (wb.ack || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_d     = cyc_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tcnt_d    = tcnt_q;
    resp_d    = resp_q;
    rdata_d   = '0;
    ready_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cyc_d   = in_window;
          we_d    = io_write_strobe;
          addr_d  = io_address[WB_ADDR_MSB:WB_ADDR_LSB];
          wdata_d = io_write_data;
          tcnt_d  = '0;
          resp_d  = '0;
        end
      end
      BUS: begin
        tcnt_d = tcnt_q + 16'd1;
        if (wb.ack) begin
          cyc_d  = 1'b0;
          resp_d = we_q ? '0 : wb.dat_o;
        end else if (expire) begin
          cyc_d     = 1'b0;
          resp_d    = TIMEOUT_DATA;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        rdata_d = resp_q;
      end
      default: ;
    endcase
  end

  assign err_inc = {1'b0, partial} + {1'b0, expire};
  assign err_sum = {1'b0, err_q} + {7'b0, err_inc};
  assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

  assign wb.cyc       = cyc_q;
  assign wb.stb       = cyc_q;
  assign wb.we        = we_q;
  assign wb.addr      = addr_q;
  assign wb.dat_i     = wdata_q;
  assign io_read_data = rdata_q;
  assign io_ready     = ready_q;
  assign bus_timeout  = timeout_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_mcs_wb_bridge.sv
// Self-checking bench for mcs_wb_bridge: directed vector table, hand sequences for
// ignored strobes / reset / saturation, and random accesses checked against a model.
module tb_mcs_wb_bridge;
  import ft_mcs_pkg::*;

  localparam int          T    = 8;
  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_E000;
  localparam logic [31:0] TDAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_addr_strobe = 1'b0, io_read_strobe = 1'b0, io_write_strobe = 1'b0;
  logic [31:0] io_address = '0, io_write_data = '0;
  logic [3:0]  io_byte_enable = '0;
  logic [31:0] io_read_data;
  logic        io_ready, bus_timeout;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  wishbone_if wb ();

  mcs_wb_bridge #(
    .ADDR_BASE(BASE), .ADDR_MASK(MASK), .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TDAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready), .wb(wb),
    .bus_timeout(bus_timeout), .err_count(err_count)
  );

  // Slave model: ACK after s_waits wait states unless s_never is set.
  int          s_waits = 0;
  logic        s_never = 1'b0;
  logic [31:0] s_data = '0;
  int          wcnt = 0;
  always @(posedge clk) begin
    if (!wb.cyc) wcnt <= 0;
    else if (!wb.ack) wcnt <= wcnt + 1;
  end
  assign wb.ack   = wb.cyc && wb.stb && !s_never && (wcnt == s_waits);
  assign wb.dat_o = s_data;

  int          n_acks = 0, n_cyc = 0, n_tmo = 0, n_rdy = 0;
  logic        s_we = 1'b0;
  logic [10:0] s_adr = '0;
  logic [31:0] s_wdat = '0;
  always @(posedge clk) begin
    if (wb.ack) begin
      n_acks <= n_acks + 1;
      s_we   <= wb.we;
      s_adr  <= wb.addr;
      s_wdat <= wb.dat_i;
    end
  end
  always @(negedge clk) begin
    if (wb.cyc) n_cyc <= n_cyc + 1;
    if (bus_timeout) n_tmo <= n_tmo + 1;
    if (io_ready) n_rdy <= n_rdy + 1;
  end

  int tests = 0, fails = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          cyc;
    bit          tmo;
    int          err_inc;
  } exp_t;

  // Expected outcome from the access rules, independent of how the bridge sequences it.
  function automatic exp_t model(bit wr, logic [31:0] a, logic [3:0] be, int waits, bit never,
                                 logic [31:0] sdata);
    exp_t m;
    bit   inwin = ((a & MASK) == BASE);
    m.err_inc = (inwin && wr && be != 4'hF) ? 1 : 0;
    m.tmo     = 0;
    if (!inwin) begin
      m.lat = 2; m.rdata = '0; m.cyc = 0;
    end else if (never || waits >= T) begin
      m.lat = T + 2; m.rdata = TDAT; m.cyc = T; m.tmo = 1; m.err_inc++;
    end else begin
      m.lat = waits + 3; m.rdata = wr ? '0 : sdata; m.cyc = waits + 1;
    end
    return m;
  endfunction

  task automatic drive_req(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_address      = a;
    io_byte_enable  = be;
    io_write_data   = wd;
    @(posedge clk); #1;
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
  endtask

  // Issues one access; lat is the cycle (strobe cycle = 0) in which io_ready was seen.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input int waits, input bit never,
                        input logic [31:0] sdata, output int lat, output logic [31:0] rdata);
    @(negedge clk);
    s_waits = waits; s_never = never; s_data = sdata;
    drive_req(rd, wr, a, be, wd);
    lat = -1; rdata = '0;
    for (int c = 1; c <= 40; c++) begin
      if (io_ready) begin
        lat = c; rdata = io_read_data;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_check(input string name, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd, input int waits,
                           input bit never, input logic [31:0] sdata, input exp_t e);
    int          lat, a0, c0, t0, r0;
    logic [31:0] rdata;
    a0 = n_acks; c0 = n_cyc; t0 = n_tmo; r0 = n_rdy;
    access(rd, wr, a, be, wd, waits, never, sdata, lat, rdata);
    check({name, " latency"}, 32'(lat), 32'(e.lat));
    check({name, " read_data"}, rdata, e.rdata);
    @(posedge clk); #1;
    check({name, " read_data cleared"}, io_read_data, '0);
    exp_err = (exp_err + e.err_inc > 255) ? 255 : exp_err + e.err_inc;
    check({name, " err_count"}, {24'h0, err_count}, 32'(exp_err));
    check({name, " cyc cycles"}, 32'(n_cyc - c0), 32'(e.cyc));
    check({name, " timeouts"}, 32'(n_tmo - t0), 32'(e.tmo));
    check({name, " ready pulses"}, 32'(n_rdy - r0), 32'd1);
    if (e.cyc > 0 && !e.tmo) begin
      check({name, " acks"}, 32'(n_acks - a0), 32'd1);
      check({name, " wb addr"}, {21'h0, s_adr}, {21'h0, a[12:2]});
      check({name, " wb we"}, {31'h0, s_we}, {31'h0, wr});
      if (wr) check({name, " wb dat_i"}, s_wdat, wd);
    end else begin
      check({name, " no acks"}, 32'(n_acks - a0), 32'd0);
    end
  endtask

  typedef struct {
    bit          rd, wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          waits;
    bit          never;
    logic [31:0] sdata;
    exp_t        e;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[$];
    exp_t        m;
    int          a0, c0, t0, r0, lat;
    logic [31:0] rdata, a;
    logic [1:0]  k;
    logic [3:0]  be;

    #1;
    check("reset io_ready", {31'h0, io_ready}, '0);
    check("reset io_read_data", io_read_data, '0);
    check("reset bus_timeout", {31'h0, bus_timeout}, '0);
    check("reset err_count", {24'h0, err_count}, '0);
    check("reset cyc", {31'h0, wb.cyc}, '0);
    check("reset stb", {31'h0, wb.stb}, '0);
    check("reset we", {31'h0, wb.we}, '0);
    check("reset addr", {21'h0, wb.addr}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    //           rd wr addr           be    wd             w  nv sdata          lat   rdata          cyc tmo err
    vecs.push_back('{0, 1, 32'hC000_0010, 4'hF, 32'h1234_5678, 0, 0, 32'h0,         '{3,     32'h0,         1, 0, 0}});
    vecs.push_back('{1, 0, 32'hC000_1FFC, 4'hF, 32'h0,         4, 0, 32'hA5A5_0001, '{7,     32'hA5A5_0001, 5, 0, 0}});
    vecs.push_back('{1, 0, 32'h8000_0000, 4'hF, 32'h0,         0, 0, 32'h7777_7777, '{2,     32'h0,         0, 0, 0}});
    vecs.push_back('{1, 0, 32'hC000_0100, 4'hF, 32'h0,         0, 1, 32'h0,         '{T + 2, TDAT,          T, 1, 1}});
    vecs.push_back('{1, 1, 32'hC000_0020, 4'hF, 32'h0000_00FF, 7, 0, 32'h5555_5555, '{T + 2, 32'h0,         T, 0, 0}});
    vecs.push_back('{1, 0, 32'hC000_0004, 4'hF, 32'h0,         8, 0, 32'h1111_1111, '{T + 2, TDAT,          T, 1, 1}});
    vecs.push_back('{0, 1, 32'hC000_0030, 4'h3, 32'hCAFE_0001, 1, 0, 32'h0,         '{4,     32'h0,         2, 0, 1}});
    vecs.push_back('{1, 0, 32'hC000_0008, 4'h0, 32'h0,         2, 0, 32'h0BAD_F00D, '{5,     32'h0BAD_F00D, 3, 0, 0}});
    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be,
                vecs[i].wd, vecs[i].waits, vecs[i].never, vecs[i].sdata, vecs[i].e);

    // Partial write with a second strobe landing while the first is on the bus.
    a0 = n_acks; c0 = n_cyc; r0 = n_rdy;
    @(negedge clk);
    s_waits = 3; s_never = 1'b0; s_data = '0;
    drive_req(1'b0, 1'b1, 32'hC000_0040, 4'h3, 32'h7777_0001);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b1, 32'hC000_0050, 4'hF, 32'h9999_9999);
    repeat (12) @(posedge clk);
    #1;
    exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
    check("ignored strobe acks", 32'(n_acks - a0), 32'd1);
    check("ignored strobe addr", {21'h0, s_adr}, 32'h0000_0010);
    check("ignored strobe we", {31'h0, s_we}, 32'd1);
    check("ignored strobe dat_i", s_wdat, 32'h7777_0001);
    check("ignored strobe ready", 32'(n_rdy - r0), 32'd1);
    check("ignored strobe cyc", 32'(n_cyc - c0), 32'd4);
    check("ignored strobe err", {24'h0, err_count}, 32'(exp_err));

    // Reset in the middle of a bus cycle.
    r0 = n_rdy; t0 = n_tmo;
    @(negedge clk);
    s_never = 1'b1;
    drive_req(1'b1, 1'b0, 32'hC000_0000, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("pre-reset cyc", {31'h0, wb.cyc}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset cyc", {31'h0, wb.cyc}, '0);
    check("async reset stb", {31'h0, wb.stb}, '0);
    check("async reset err", {24'h0, err_count}, '0);
    exp_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("reset no ready", 32'(n_rdy - r0), '0);
    check("reset no timeout", 32'(n_tmo - t0), '0);
    m = model(1'b0, 32'hC000_0044, 4'hF, 2, 1'b0, 32'h1357_9BDF);
    run_check("post-reset read", 1'b1, 1'b0, 32'hC000_0044, 4'hF, 32'h0, 2, 1'b0,
              32'h1357_9BDF, m);

    for (int i = 0; i < 120; i++) begin
      k  = 2'($urandom_range(1, 3));
      a  = ($urandom_range(0, 3) != 0) ? (BASE | ($urandom & ~MASK)) : $urandom;
      be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      m  = model(k[1], a, be, 0, 1'b0, 32'h0);
      begin
        int          w = $urandom_range(0, 10);
        bit          nv = ($urandom_range(0, 7) == 0);
        logic [31:0] sd = $urandom;
        logic [31:0] wd = $urandom;
        m = model(k[1], a, be, w, nv, sd);
        run_check($sformatf("rand%0d", i), k[0], k[1], a, be, wd, w, nv, sd, m);
      end
    end

    // Saturation: 300 timeouts must pin err_count at 8'hFF.
    t0 = n_tmo;
    for (int i = 0; i < 300; i++)
      access(1'b1, 1'b0, 32'hC000_0200, 4'hF, 32'h0, 0, 1'b1, 32'h0, lat, rdata);
    @(posedge clk); #1;
    check("saturation timeouts", 32'(n_tmo - t0), 32'd300);
    check("saturation err_count", {24'h0, err_count}, 32'h0000_00FF);
    check("saturation last data", rdata, TDAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
